// File: rtl/femto_clkctl.sv
// femto_clkctl: reset sequencer and clock-enable generator behind the PLL.
// Ports: clk, reset (sync, active-high), pll_lock (async),
//   cfg_we/cfg_ch/cfg_div (divisor writes),
//   ce_out[NCH] (enable strobes), sys_reset_out, ready.
module femto_clkctl #(
    parameter int NCH         = 4,
    parameter int CHW         = 2,
    parameter int DIVW        = 16,
    parameter int DEFAULT_DIV = 0,
    parameter int LOCK_CYCLES = 16,
    parameter int RST_CYCLES  = 8,
    parameter int SEQW        = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            pll_lock,
    input  logic            cfg_we,
    input  logic [CHW-1:0]  cfg_ch,
    input  logic [DIVW-1:0] cfg_div,
    output logic [NCH-1:0]  ce_out,
    output logic            sys_reset_out,
    output logic            ready
);

    typedef enum logic [1:0] {
        WAIT_LOCK,
        STABLE,
        HOLD,
        RUN
    } state_t;

    localparam logic [SEQW-1:0] LOCK_LAST = SEQW'(LOCK_CYCLES - 1);
    localparam logic [SEQW-1:0] RST_LAST  = SEQW'(RST_CYCLES - 1);
    localparam logic [DIVW-1:0] DIV_RST   = DIVW'(DEFAULT_DIV);

    state_t          state_q, state_d;
    logic [1:0]      sync_q, sync_d;
    logic [SEQW-1:0] seq_q, seq_d;
    logic [DIVW-1:0] div_q [NCH];
    logic [DIVW-1:0] div_d [NCH];
    logic [DIVW-1:0] cnt_q [NCH];
    logic [DIVW-1:0] cnt_d [NCH];
    logic            lock_s;
    logic            run_stay;

    assign lock_s = sync_q[1];

    always_comb begin
        sync_d = {sync_q[0], pll_lock};
    end

    always_comb begin
        state_d = state_q;
        seq_d   = seq_q;
        unique case (state_q)
            WAIT_LOCK: begin
                seq_d = '0;
                if (lock_s) state_d = STABLE;
            end
            STABLE: begin
                if (!lock_s) begin
                    state_d = WAIT_LOCK;
                    seq_d   = '0;
                end else if (seq_q == LOCK_LAST) begin
                    state_d = HOLD;
                    seq_d   = '0;
                end else begin
                    seq_d = seq_q + SEQW'(1);
                end
            end
            HOLD: begin
                if (!lock_s) begin
                    state_d = WAIT_LOCK;
                    seq_d   = '0;
                end else if (seq_q == RST_LAST) begin
                    state_d = RUN;
                    seq_d   = '0;
                end else begin
                    seq_d = seq_q + SEQW'(1);
                end
            end
            RUN: begin
                seq_d = '0;
                if (!lock_s) state_d = WAIT_LOCK;
            end
            default: begin
                state_d = WAIT_LOCK;
                seq_d   = '0;
            end
        endcase
    end

    // Counters only advance while RUN persists; leaving RUN zeroes them
    // so the next RUN entry starts from a clean phase.
    assign run_stay = (state_q == RUN) && (state_d == RUN);

    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            div_d[i] = div_q[i];
            cnt_d[i] = '0;
            if (run_stay) begin
                if (cnt_q[i] == div_q[i]) cnt_d[i] = '0;
                else cnt_d[i] = cnt_q[i] + DIVW'(1);
            end
            // Out-of-range channel numbers match no index and are dropped.
            if (cfg_we && (cfg_ch == CHW'(i))) begin
                div_d[i] = cfg_div;
                cnt_d[i] = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= WAIT_LOCK;
            sync_q  <= '0;
            seq_q   <= '0;
            for (int i = 0; i < NCH; i++) begin
                div_q[i] <= DIV_RST;
                cnt_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            sync_q  <= sync_d;
            seq_q   <= seq_d;
            for (int i = 0; i < NCH; i++) begin
                div_q[i] <= div_d[i];
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    // Gated by reset so downstream logic sees reset asserted
    // during the reset cycle itself, not only after the edge.
    assign ready         = !reset && (state_q == RUN);
    assign sys_reset_out = !ready;

    always_comb begin
        ce_out = '0;
        for (int i = 0; i < NCH; i++) begin
            ce_out[i] = ready && (cnt_q[i] == div_q[i]);
        end
    end

endmodule

// File: tb/tb_femto_clkctl.sv
// Directed bench for femto_clkctl: lock sequencing, divisor writes,
// lock loss, mid-run reset and the widest divisor.
module tb_femto_clkctl;

    localparam int NCH  = 4;
    localparam int CHW  = 3;
    localparam int DIVW = 8;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            pll_lock = 1'b0;
    logic            cfg_we = 1'b0;
    logic [CHW-1:0]  cfg_ch = '0;
    logic [DIVW-1:0] cfg_div = '0;
    logic [NCH-1:0]  ce_out;
    logic            sys_reset_out;
    logic            ready;

    femto_clkctl #(
        .NCH(NCH), .CHW(CHW), .DIVW(DIVW), .DEFAULT_DIV(0),
        .LOCK_CYCLES(4), .RST_CYCLES(3), .SEQW(8)
    ) dut (
        .clk(clk), .reset(reset), .pll_lock(pll_lock),
        .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_div(cfg_div),
        .ce_out(ce_out), .sys_reset_out(sys_reset_out), .ready(ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        string          tag;
        logic [NCH-1:0] ce;
        logic           rs;
        logic           rd;
    } exp_t;

    exp_t sb[$];
    int   nchecks = 0;
    int   nerr = 0;

    task automatic check_out();
        exp_t e;
        e = sb.pop_front();
        nchecks++;
        assert ({ce_out, sys_reset_out, ready} === {e.ce, e.rs, e.rd})
        else begin
            nerr++;
            $error("FAIL %s: ce=%b rst=%b rdy=%b, expected ce=%b rst=%b rdy=%b",
                   e.tag, ce_out, sys_reset_out, ready, e.ce, e.rs, e.rd);
        end
    endtask

    task automatic tick(input string tag, input logic [NCH-1:0] ce,
                        input logic rs, input logic rd);
        sb.push_back('{tag, ce, rs, rd});
        @(posedge clk);
        #1;
        check_out();
    endtask

    task automatic peek(input string tag, input logic [NCH-1:0] ce,
                        input logic rs, input logic rd);
        sb.push_back('{tag, ce, rs, rd});
        #1;
        check_out();
    endtask

    task automatic wr(input int ch, input int dv);
        cfg_we  = 1'b1;
        cfg_ch  = CHW'(ch);
        cfg_div = DIVW'(dv);
    endtask

    // pll_lock must already be high; ready appears on the 10th edge.
    task automatic lockup(input string tag, input logic [NCH-1:0] run_ce);
        for (int k = 1; k <= 10; k++) begin
            if (k == 10) tick(tag, run_ce, 1'b0, 1'b1);
            else tick(tag, '0, 1'b1, 1'b0);
        end
    endtask

    initial begin
        logic [NCH-1:0] e;

        tick("rst", '0, 1'b1, 1'b0);
        tick("rst", '0, 1'b1, 1'b0);
        reset = 1'b0;
        tick("idle", '0, 1'b1, 1'b0);
        tick("idle", '0, 1'b1, 1'b0);

        pll_lock = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            if (k == 4) pll_lock = 1'b0;
            tick("pulse", '0, 1'b1, 1'b0);
        end

        pll_lock = 1'b1;
        lockup("lock", 4'hF);
        for (int k = 0; k < 3; k++) tick("run_div0", 4'hF, 1'b0, 1'b1);

        for (int t = 1; t <= 44; t++) begin
            cfg_we = 1'b0;
            if (t == 1) wr(2, 3);
            if (t == 13) begin
                wr(1, 5);
                peek("wr_ce_kept", 4'hF, 1'b0, 1'b1);
            end
            if (t == 25) wr(7, 9);
            if (t == 37) wr(0, 2);
            if (t == 43) pll_lock = 1'b0;
            e[3] = 1'b1;
            e[2] = (t % 4 == 0);
            e[1] = (t < 13) ? 1'b1 : ((t - 12) % 6 == 0);
            e[0] = (t < 37) ? 1'b1 : ((t - 36) % 3 == 0);
            tick("chan", e, 1'b0, 1'b1);
        end
        cfg_we = 1'b0;

        for (int k = 0; k < 4; k++) tick("drop", '0, 1'b1, 1'b0);

        pll_lock = 1'b1;
        for (int k = 1; k <= 9; k++) tick("relock", '0, 1'b1, 1'b0);
        for (int j = 0; j <= 12; j++) begin
            e[3] = 1'b1;
            e[2] = (j % 4 == 3);
            e[1] = (j % 6 == 5);
            e[0] = (j % 3 == 2);
            tick("relock_run", e, 1'b0, 1'b1);
        end

        reset = 1'b1;
        peek("rst_comb", '0, 1'b1, 1'b0);
        tick("rst_mid", '0, 1'b1, 1'b0);
        reset = 1'b0;
        lockup("post_rst", 4'hF);
        for (int k = 0; k < 3; k++) tick("default_div", 4'hF, 1'b0, 1'b1);

        for (int c = 1; c <= 513; c++) begin
            cfg_we = 1'b0;
            if (c == 1) wr(3, 255);
            e = 4'b0111;
            e[3] = (c % 256 == 0);
            tick("div_max", e, 1'b0, 1'b1);
        end
        cfg_we = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
        $finish;
    end

endmodule
